// File: rtl/adat_frame_deframer.sv
`default_nettype none
// ============================================================================
// Module   : adat_frame_deframer
// Brief    : Aligns to 256-bit ADAT frames and emits user bits and 8 samples.
// Revision : 1.0 - initial release
// ============================================================================
module adat_frame_deframer #(
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        tick_ni,
    input  logic        data_i,
    input  logic        valid_i,
    input  logic        sync_i,
    output logic [23:0] sample_o,
    output logic [2:0]  channel_o,
    output logic        sample_valid_o,
    output logic [3:0]  user_o,
    output logic        frame_done_o,
    output logic        locked_o,
    output logic        frame_error_o
);

    typedef enum logic [1:0] {
        S_HUNT = 2'd0,
        S_USER = 2'd1,
        S_CHAN = 2'd2,
        S_SYNC = 2'd3
    } state_t;

    localparam logic [2:0] c_lock_frames = 3'(LOCK_FRAMES);

    state_t      r_state, w_state;
    logic [3:0]  r_run, w_run;
    logic [4:0]  r_pos, w_pos;
    logic [2:0]  r_chan, w_chan;
    logic [23:0] r_shift, w_shift;
    logic [3:0]  r_user_sh, w_user_sh;
    logic [2:0]  r_good, w_good;

    logic [23:0] w_sample;
    logic [2:0]  w_channel;
    logic [3:0]  w_user;
    logic        w_sample_valid, w_frame_done, w_locked, w_frame_error;

    logic        w_accept, w_is_sep, w_fail;
    logic [3:0]  w_run_inc;
    logic [2:0]  w_good_inc;

    assign w_accept   = !tick_ni && valid_i && sync_i;
    assign w_run_inc  = (r_run == 4'd15) ? 4'd15 : r_run + 4'd1;
    assign w_good_inc = (r_good == 3'd7) ? 3'd7 : r_good + 3'd1;
    assign w_is_sep   = (r_pos == 5'd4)  || (r_pos == 5'd9)  || (r_pos == 5'd14) ||
                        (r_pos == 5'd19) || (r_pos == 5'd24) || (r_pos == 5'd29);

    always_comb begin
        w_state        = r_state;
        w_run          = r_run;
        w_pos          = r_pos;
        w_chan         = r_chan;
        w_shift        = r_shift;
        w_user_sh      = r_user_sh;
        w_good         = r_good;
        w_sample       = sample_o;
        w_channel      = channel_o;
        w_user         = user_o;
        w_locked       = locked_o;
        w_sample_valid = 1'b0;
        w_frame_done   = 1'b0;
        w_frame_error  = 1'b0;
        w_fail         = 1'b0;

        if (!sync_i) begin
            // Decoder lost phase: silent realignment, no error strobe.
            w_state  = S_HUNT;
            w_run    = 4'd0;
            w_pos    = 5'd0;
            w_chan   = 3'd0;
            w_good   = 3'd0;
            w_locked = 1'b0;
        end else if (w_accept) begin
            case (r_state)
                S_HUNT: begin
                    if (data_i) begin
                        if (r_run >= 4'd10) begin
                            w_state = S_USER;
                            w_pos   = 5'd0;
                        end
                        w_run = 4'd0;
                    end else begin
                        w_run = w_run_inc;
                    end
                end
                S_USER: begin
                    if (r_pos == 5'd4) begin
                        if (data_i) begin
                            w_state = S_CHAN;
                            w_pos   = 5'd0;
                            w_chan  = 3'd0;
                        end else begin
                            w_fail = 1'b1;
                        end
                    end else begin
                        w_user_sh = {r_user_sh[2:0], data_i};
                        w_pos     = r_pos + 5'd1;
                    end
                end
                S_CHAN: begin
                    if (w_is_sep) begin
                        if (!data_i) begin
                            w_fail = 1'b1;
                        end else if (r_pos == 5'd29) begin
                            w_sample       = r_shift;
                            w_channel      = r_chan;
                            w_sample_valid = 1'b1;
                            w_pos          = 5'd0;
                            if (r_chan == 3'd7) begin
                                w_frame_done = 1'b1;
                                w_user       = r_user_sh;
                                w_state      = S_SYNC;
                                w_run        = 4'd0;
                            end else begin
                                w_chan = r_chan + 3'd1;
                            end
                        end else begin
                            w_pos = r_pos + 5'd1;
                        end
                    end else begin
                        w_shift = {r_shift[22:0], data_i};
                        w_pos   = r_pos + 5'd1;
                    end
                end
                default: begin
                    if (data_i) begin
                        if (r_run == 4'd10) begin
                            w_state  = S_USER;
                            w_pos    = 5'd0;
                            w_run    = 4'd0;
                            w_good   = w_good_inc;
                            w_locked = (w_good_inc >= c_lock_frames);
                        end else begin
                            w_fail = 1'b1;
                        end
                    end else if (r_run == 4'd10) begin
                        w_fail = 1'b1;
                    end else begin
                        w_run = w_run_inc;
                    end
                end
            endcase

            // The offending bit seeds the hunt so a long sync run still aligns.
            if (w_fail) begin
                w_frame_error = 1'b1;
                w_good        = 3'd0;
                w_locked      = 1'b0;
                w_state       = S_HUNT;
                w_pos         = 5'd0;
                w_chan        = 3'd0;
                w_run         = data_i ? 4'd0 : w_run_inc;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state        <= S_HUNT;
            r_run          <= 4'd0;
            r_pos          <= 5'd0;
            r_chan         <= 3'd0;
            r_shift        <= 24'd0;
            r_user_sh      <= 4'd0;
            r_good         <= 3'd0;
            sample_o       <= 24'd0;
            channel_o      <= 3'd0;
            sample_valid_o <= 1'b0;
            user_o         <= 4'd0;
            frame_done_o   <= 1'b0;
            locked_o       <= 1'b0;
            frame_error_o  <= 1'b0;
        end else begin
            r_state        <= w_state;
            r_run          <= w_run;
            r_pos          <= w_pos;
            r_chan         <= w_chan;
            r_shift        <= w_shift;
            r_user_sh      <= w_user_sh;
            r_good         <= w_good;
            sample_o       <= w_sample;
            channel_o      <= w_channel;
            sample_valid_o <= w_sample_valid;
            user_o         <= w_user;
            frame_done_o   <= w_frame_done;
            locked_o       <= w_locked;
            frame_error_o  <= w_frame_error;
        end
    end

endmodule
`default_nettype wire
